// File: rtl/param_wait_check_counter_pkg.sv
// Shared types and defaults for the wait/check counter.
// State encoding is fixed: IDLE=0, WAIT=1, CHECK=2, STOP=3.
package param_wait_check_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DEF_TIMER_W    = 5;
    localparam int DEF_COUNT_W    = 5;
    localparam int DEF_MAX_CHECKS = 16;

endpackage

// File: rtl/param_wait_check_counter_if.sv
// Control and status bundle of the wait/check counter.
// The master drives the run controls, the slave reports progress.
interface param_wait_check_counter_if
    import param_wait_check_counter_pkg::*;
#(
    parameter int TIMER_W = DEF_TIMER_W,
    parameter int COUNT_W = DEF_COUNT_W
);
    logic               start;
    logic               abort;
    logic               flag;
    logic [TIMER_W-1:0] wait_timer;
    logic               mode;
    logic               busy;
    logic [COUNT_W-1:0] count;
    logic               done;
    logic               aborted;
    logic [1:0]         state;

    modport master (
        output start, abort, flag, wait_timer, mode,
        input  busy, count, done, aborted, state
    );

    modport slave (
        input  start, abort, flag, wait_timer, mode,
        output busy, count, done, aborted, state
    );
endinterface

// File: rtl/param_wait_check_counter_rise.sv
// Rising-edge detector: one-cycle rise when in goes 0->1.
// The previous sample is registered every cycle.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic prev_q;

    // remember last cycle's input level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= in;
    end

    assign rise = in & ~prev_q;
endmodule

// File: rtl/param_wait_check_counter.sv
// Wait/check run controller: waits wait_timer+1 cycles, samples flag,
// repeats until a hit (one-shot) or MAX_CHECKS checks (multi).
module param_wait_check_counter
    import param_wait_check_counter_pkg::*;
#(
    parameter int TIMER_W    = DEF_TIMER_W,
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int MAX_CHECKS = DEF_MAX_CHECKS
) (
    input logic                       clk,
    input logic                       rst,
    param_wait_check_counter_if.slave bus
);
    localparam int CHK_W = $clog2(MAX_CHECKS + 1);
    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(MAX_CHECKS);

    state_t             state_q, state_n;
    logic [TIMER_W-1:0] timer_q, timer_n;
    logic [COUNT_W-1:0] count_q, count_n;
    logic [CHK_W-1:0]   chk_q, chk_n, chk_inc;
    logic               mode_q, mode_n;
    logic               aborted_q, aborted_n;
    logic               done_q, busy_q;
    logic               start_rise;

    rise_edge_det u_rise (
        .clk  (clk),
        .rst  (rst),
        .in   (bus.start),
        .rise (start_rise)
    );

    assign chk_inc = chk_q + 1'b1;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    // run datapath; done/busy are decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q   <= '0;
            count_q   <= '0;
            chk_q     <= '0;
            mode_q    <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            timer_q   <= timer_n;
            count_q   <= count_n;
            chk_q     <= chk_n;
            mode_q    <= mode_n;
            aborted_q <= aborted_n;
            done_q    <= (state_n == ST_STOP);
            busy_q    <= (state_n == ST_WAIT) || (state_n == ST_CHECK);
        end
    end

    // next state and next datapath values; abort outranks every CHECK decision
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        count_n   = count_q;
        chk_n     = chk_q;
        mode_n    = mode_q;
        aborted_n = aborted_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_n   = ST_WAIT;
                    timer_n   = bus.wait_timer;
                    mode_n    = bus.mode;
                    count_n   = '0;
                    chk_n     = '0;
                    aborted_n = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    state_n   = ST_STOP;
                    aborted_n = 1'b1;
                end else if (timer_q == '0) begin
                    state_n = ST_CHECK;
                end else begin
                    timer_n = timer_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (bus.abort) begin
                    state_n   = ST_STOP;
                    aborted_n = 1'b1;
                end else begin
                    if (bus.flag && (count_q != '1))
                        count_n = count_q + 1'b1;
                    chk_n = chk_inc;
                    if ((!mode_q && bus.flag) || (chk_inc == CHK_LAST)) begin
                        state_n = ST_STOP;
                    end else begin
                        state_n = ST_WAIT;
                        timer_n = bus.wait_timer;
                    end
                end
            end
            ST_STOP: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.state   = state_q;
    assign bus.busy    = busy_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_param_wait_check_counter.sv
// Bench for param_wait_check_counter: two instances (MAX_CHECKS=4/COUNT_W=5
// and MAX_CHECKS=6/COUNT_W=2) share stimulus and are checked per cycle.
module tb_param_wait_check_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic flag_i = 1'b0;
    logic mode_i = 1'b0;
    logic [4:0] wt_i = '0;

    int total = 0;
    int bad = 0;
    bit flags [16];

    always #5 clk = ~clk;

    param_wait_check_counter_if #(.TIMER_W(5), .COUNT_W(5)) if0 ();
    param_wait_check_counter_if #(.TIMER_W(5), .COUNT_W(2)) if1 ();

    assign if0.start = start_i;
    assign if0.abort = abort_i;
    assign if0.flag = flag_i;
    assign if0.mode = mode_i;
    assign if0.wait_timer = wt_i;
    assign if1.start = start_i;
    assign if1.abort = abort_i;
    assign if1.flag = flag_i;
    assign if1.mode = mode_i;
    assign if1.wait_timer = wt_i;

    param_wait_check_counter #(.TIMER_W(5), .COUNT_W(5), .MAX_CHECKS(4)) u0 (
        .clk(clk), .rst(rst), .bus(if0));
    param_wait_check_counter #(.TIMER_W(5), .COUNT_W(2), .MAX_CHECKS(6)) u1 (
        .clk(clk), .rst(rst), .bus(if1));

    logic [1:0] o_st [2];
    logic o_busy [2];
    logic o_done [2];
    logic o_ab [2];
    int o_cnt [2];

    assign o_st[0] = if0.state;
    assign o_st[1] = if1.state;
    assign o_busy[0] = if0.busy;
    assign o_busy[1] = if1.busy;
    assign o_done[0] = if0.done;
    assign o_done[1] = if1.done;
    assign o_ab[0] = if0.aborted;
    assign o_ab[1] = if1.aborted;
    assign o_cnt[0] = int'(if0.count);
    assign o_cnt[1] = int'(if1.count);

    // Run-level model: check i happens at cycle i*(wt+2)+wt+1 counted from
    // the first WAIT cycle; s is the cycle in which STOP is seen.
    task automatic model(input int mx, input int cmax, input bit m,
                         input int wt, input int a,
                         output int s, output int cnt, output bit ab);
        int p;
        int hits;
        int cc;
        p = wt + 2;
        hits = 0;
        s = 0;
        ab = 1'b0;
        for (int i = 0; i < mx; i++) begin
            cc = i * p + wt + 1;
            if (a >= 0 && a <= cc) begin
                s = a + 1;
                ab = 1'b1;
                break;
            end
            hits += int'(flags[i]);
            if ((!m && flags[i]) || (i + 1 == mx)) begin
                s = cc + 1;
                break;
            end
        end
        cnt = (hits > cmax) ? cmax : hits;
    endtask

    task automatic do_run(input bit m, input int wt, input int a, input bit hold);
        int s [2];
        int cn [2];
        bit ab [2];
        int p;
        int smax;
        int es;
        int ec;
        bit eb;
        p = wt + 2;
        model(4, 31, m, wt, a, s[0], cn[0], ab[0]);
        model(6, 3, m, wt, a, s[1], cn[1], ab[1]);
        smax = ((s[0] > s[1]) ? s[0] : s[1]) + (hold ? 4 : 1);
        mode_i = m;
        wt_i = 5'(wt);
        abort_i = 1'b0;
        flag_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c <= smax; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (c < s[k]) es = ((c % p) == wt + 1) ? 2 : 1;
                else es = (c == s[k]) ? 3 : 0;
                total++;
                if (o_st[k] !== 2'(es)) begin
                    bad++;
                    $display("FAIL state k=%0d c=%0d got %0d want %0d", k, c, o_st[k], es);
                end
                total++;
                if (o_busy[k] !== (c < s[k])) begin
                    bad++;
                    $display("FAIL busy k=%0d c=%0d got %0b want %0b", k, c, o_busy[k], c < s[k]);
                end
                total++;
                if (o_done[k] !== (c == s[k])) begin
                    bad++;
                    $display("FAIL done k=%0d c=%0d got %0b want %0b", k, c, o_done[k], c == s[k]);
                end
                if (c == 0 || c >= s[k]) begin
                    ec = (c >= s[k]) ? cn[k] : 0;
                    eb = (c >= s[k]) ? ab[k] : 1'b0;
                    total++;
                    if (o_cnt[k] !== ec) begin
                        bad++;
                        $display("FAIL count k=%0d c=%0d got %0d want %0d", k, c, o_cnt[k], ec);
                    end
                    total++;
                    if (o_ab[k] !== eb) begin
                        bad++;
                        $display("FAIL aborted k=%0d c=%0d got %0b want %0b", k, c, o_ab[k], eb);
                    end
                end
            end
            start_i = hold;
            abort_i = (c == a);
            if ((c % p) == wt + 1 && (c / p) < 16) flag_i = flags[c / p];
            else flag_i = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_st[k] !== 2'd0 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 ||
                o_cnt[k] !== 0 || o_ab[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset k=%0d got st=%0d busy=%0b done=%0b cnt=%0d ab=%0b want all 0",
                         k, o_st[k], o_busy[k], o_done[k], o_cnt[k], o_ab[k]);
            end
        end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_shot();
        for (int i = 0; i < 16; i++) flags[i] = 1'b1;
        do_run(1'b0, 3, -1, 1'b0);
    endtask

    task automatic test_multi();
        for (int i = 0; i < 16; i++) flags[i] = 1'b0;
        flags[0] = 1'b1;
        flags[2] = 1'b1;
        flags[3] = 1'b1;
        flags[4] = 1'b1;
        flags[5] = 1'b1;
        do_run(1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) flags[i] = 1'b1;
        do_run(1'b1, 1, -1, 1'b0);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) flags[i] = 1'b1;
        do_run(1'b1, 5, 1, 1'b0);
    endtask

    task automatic test_abort_idle();
        abort_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_st[k] !== 2'd0 || o_done[k] !== 1'b0 || o_ab[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_idle k=%0d got st=%0d done=%0b ab=%0b want 0 0 1",
                             k, o_st[k], o_done[k], o_ab[k]);
                end
            end
        end
        abort_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_hold();
        for (int i = 0; i < 16; i++) flags[i] = 1'b1;
        do_run(1'b0, 1, -1, 1'b1);
        do_run(1'b0, 1, -1, 1'b0);
    endtask

    task automatic test_random();
        int wt;
        int a;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) flags[i] = 1'($urandom);
            wt = $urandom_range(0, 4);
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
            do_run(1'($urandom), wt, a, ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) flags[i] = 1'b1;
        mode_i = 1'b1;
        wt_i = 5'd2;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            flag_i = 1'b1;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_st[k] !== 2'd2) begin
                bad++;
                $display("FAIL pre_reset_state k=%0d got %0d want 2", k, o_st[k]);
            end
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_st[k] !== 2'd0 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 ||
                o_cnt[k] !== 0 || o_ab[k] !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset k=%0d got st=%0d busy=%0b done=%0b cnt=%0d ab=%0b want all 0",
                         k, o_st[k], o_busy[k], o_done[k], o_cnt[k], o_ab[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_st[k] !== 2'd0 || o_done[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL post_reset k=%0d got st=%0d done=%0b want 0 0",
                             k, o_st[k], o_done[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_multi();
        test_saturate();
        test_abort();
        test_abort_idle();
        test_start_hold();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
